// File: rtl/mem_arb_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port data memory.
// Signal directions are named from the arbiter's point of view.
interface mem_arb_if;
    // ctrl encoding: [1]=read, [0]=write
    typedef logic [1:0] mem_ctrl_t;

    logic        i_m0_req;
    logic [31:0] i_m0_addr;
    logic [31:0] i_m0_wdata;
    mem_ctrl_t   i_m0_ctrl;
    logic        o_m0_gnt;
    logic        o_m0_rvalid;
    logic [31:0] o_m0_rdata;

    logic        i_m1_req;
    logic [31:0] i_m1_addr;
    logic [31:0] i_m1_wdata;
    mem_ctrl_t   i_m1_ctrl;
    logic        o_m1_gnt;
    logic        o_m1_rvalid;
    logic [31:0] o_m1_rdata;

    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic        o_mem_we;
    logic        o_mem_re;
    logic [31:0] i_mem_rdata;

    logic        o_proto_err;

    modport slave (
        input  i_m0_req, i_m0_addr, i_m0_wdata, i_m0_ctrl,
        output o_m0_gnt, o_m0_rvalid, o_m0_rdata,
        input  i_m1_req, i_m1_addr, i_m1_wdata, i_m1_ctrl,
        output o_m1_gnt, o_m1_rvalid, o_m1_rdata,
        output o_mem_addr, o_mem_wdata, o_mem_we, o_mem_re,
        input  i_mem_rdata,
        output o_proto_err
    );

    modport master (
        output i_m0_req, i_m0_addr, i_m0_wdata, i_m0_ctrl,
        input  o_m0_gnt, o_m0_rvalid, o_m0_rdata,
        output i_m1_req, i_m1_addr, i_m1_wdata, i_m1_ctrl,
        input  o_m1_gnt, o_m1_rvalid, o_m1_rdata,
        input  o_mem_addr, o_mem_wdata, o_mem_we, o_mem_re,
        output i_mem_rdata,
        input  o_proto_err
    );
endinterface

// File: rtl/mem_arb.sv
// Two-requester arbiter/sequencer for the single-port data memory: fixed m0 priority
// with a bounded-starvation override for m1, and tracking of one outstanding read.
module mem_arb #(
    parameter int RD_LATENCY    = 1,
    parameter int MAX_M0_STREAK = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    mem_arb_if.slave    bus
);

    localparam logic [2:0] LAT        = 3'(RD_LATENCY);
    localparam logic [3:0] STREAK_MAX = 4'(MAX_M0_STREAK);

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_t;

    state_t      r_state, w_state_next;
    logic [2:0]  r_rd_cnt, w_rd_cnt_next;
    logic        r_rd_owner, w_rd_owner_next;
    logic [3:0]  r_streak, w_streak_next;
    logic        r_proto_err, w_proto_err_next;

    logic        w_req   [2];
    logic [31:0] w_addr  [2];
    logic [31:0] w_wdata [2];
    logic [1:0]  w_ctrl  [2];
    logic        w_gnt   [2];
    logic        w_rvalid[2];

    logic        w_complete;
    logic        w_arb_en;
    logic        w_sel;
    logic        w_any_gnt;
    logic [1:0]  w_sel_ctrl;
    logic        w_mem_we;
    logic        w_mem_re;

    assign w_req[0]   = bus.i_m0_req;
    assign w_addr[0]  = bus.i_m0_addr;
    assign w_wdata[0] = bus.i_m0_wdata;
    assign w_ctrl[0]  = bus.i_m0_ctrl;
    assign w_req[1]   = bus.i_m1_req;
    assign w_addr[1]  = bus.i_m1_addr;
    assign w_wdata[1] = bus.i_m1_wdata;
    assign w_ctrl[1]  = bus.i_m1_ctrl;

    // The completion cycle of a read doubles as an arbitration slot so back-to-back
    // reads run at one per RD_LATENCY cycles.
    assign w_complete = (r_state == RD_WAIT) && (r_rd_cnt == 3'd1);
    assign w_arb_en   = !i_reset && ((r_state == IDLE) || w_complete);

    always_comb begin
        w_gnt[0]         = 1'b0;
        w_gnt[1]         = 1'b0;
        w_state_next     = r_state;
        w_rd_cnt_next    = r_rd_cnt;
        w_rd_owner_next  = r_rd_owner;
        w_streak_next    = r_streak;
        w_proto_err_next = r_proto_err;

        if (w_arb_en) begin
            if (w_req[0] && w_req[1]) begin
                if (r_streak == STREAK_MAX)
                    w_gnt[1] = 1'b1;
                else
                    w_gnt[0] = 1'b1;
            end else if (w_req[0]) begin
                w_gnt[0] = 1'b1;
            end else if (w_req[1]) begin
                w_gnt[1] = 1'b1;
            end
        end

        w_sel      = w_gnt[1];
        w_any_gnt  = w_gnt[0] | w_gnt[1];
        w_sel_ctrl = w_ctrl[w_sel];
        // ctrl 11 behaves as a write; only a pure 10 strobes a read
        w_mem_we   = w_any_gnt & w_sel_ctrl[0];
        w_mem_re   = w_any_gnt & w_sel_ctrl[1] & ~w_sel_ctrl[0];

        if (r_state == RD_WAIT) begin
            w_rd_cnt_next = r_rd_cnt - 3'd1;
            if (w_complete)
                w_state_next = IDLE;
        end
        if (w_mem_re) begin
            w_state_next    = RD_WAIT;
            w_rd_cnt_next   = LAT;
            w_rd_owner_next = w_sel;
        end

        if (!w_req[1] || w_gnt[1])
            w_streak_next = 4'd0;
        else if (w_gnt[0] && (r_streak != STREAK_MAX))
            w_streak_next = r_streak + 4'd1;

        if (w_any_gnt && (w_sel_ctrl == 2'b11))
            w_proto_err_next = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_rd_cnt    <= 3'd0;
            r_rd_owner  <= 1'b0;
            r_streak    <= 4'd0;
            r_proto_err <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_rd_cnt    <= w_rd_cnt_next;
            r_rd_owner  <= w_rd_owner_next;
            r_streak    <= w_streak_next;
            r_proto_err <= w_proto_err_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_resp
            assign w_rvalid[gi] = w_complete && !i_reset && (r_rd_owner == gi[0]);
        end
    endgenerate

    assign bus.o_m0_gnt    = w_gnt[0];
    assign bus.o_m1_gnt    = w_gnt[1];
    assign bus.o_m0_rvalid = w_rvalid[0];
    assign bus.o_m1_rvalid = w_rvalid[1];
    assign bus.o_m0_rdata  = bus.i_mem_rdata;
    assign bus.o_m1_rdata  = bus.i_mem_rdata;

    // With no grant w_sel is 0, so the address/data lines idle on m0's values.
    assign bus.o_mem_addr  = w_addr[w_sel];
    assign bus.o_mem_wdata = w_wdata[w_sel];
    assign bus.o_mem_we    = w_mem_we;
    assign bus.o_mem_re    = w_mem_re;
    assign bus.o_proto_err = r_proto_err;

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: one instance at RD_LATENCY=1 backed by a small memory
// model, one at RD_LATENCY=3 fed a constant read word.
module tb_mem_arb;

    logic i_clk;
    logic rst1;
    logic rst3;
    int   total;
    int   bad;

    mem_arb_if bus1 ();
    mem_arb_if bus3 ();

    mem_arb #(.RD_LATENCY(1), .MAX_M0_STREAK(4)) dut_l1 (
        .i_clk   (i_clk),
        .i_reset (rst1),
        .bus     (bus1)
    );

    mem_arb #(.RD_LATENCY(3), .MAX_M0_STREAK(4)) dut_l3 (
        .i_clk   (i_clk),
        .i_reset (rst3),
        .bus     (bus3)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Word-addressed memory with a one-cycle registered read
    logic [31:0] mem [256];
    logic [31:0] rd_q;
    always @(posedge i_clk) begin
        if (bus1.o_mem_we)
            mem[bus1.o_mem_addr[9:2]] <= bus1.o_mem_wdata;
        if (bus1.o_mem_re)
            rd_q <= mem[bus1.o_mem_addr[9:2]];
    end
    assign bus1.i_mem_rdata = rd_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        logic exp_m1;
        logic prev_m1;
        total = 0;
        bad   = 0;

        // ---- reset with both requesters active ----
        rst1 = 1'b1;
        rst3 = 1'b1;
        bus1.i_m0_req = 1'b1; bus1.i_m0_ctrl = 2'b01;
        bus1.i_m0_addr = 32'h100; bus1.i_m0_wdata = 32'hDEADBEEF;
        bus1.i_m1_req = 1'b1; bus1.i_m1_ctrl = 2'b10;
        bus1.i_m1_addr = 32'h200; bus1.i_m1_wdata = 32'h0;
        bus3.i_m0_req = 1'b0; bus3.i_m0_ctrl = 2'b00;
        bus3.i_m0_addr = 32'h0; bus3.i_m0_wdata = 32'h0;
        bus3.i_m1_req = 1'b0; bus3.i_m1_ctrl = 2'b00;
        bus3.i_m1_addr = 32'h0; bus3.i_m1_wdata = 32'h0;
        bus3.i_mem_rdata = 32'hCAFE0003;
        settle();
        chk("rst_gnt0", 32'(bus1.o_m0_gnt), 32'd0);
        chk("rst_gnt1", 32'(bus1.o_m1_gnt), 32'd0);
        chk("rst_we", 32'(bus1.o_mem_we), 32'd0);
        chk("rst_re", 32'(bus1.o_mem_re), 32'd0);
        chk("rst_rvalid0", 32'(bus1.o_m0_rvalid), 32'd0);
        chk("rst_proto", 32'(bus1.o_proto_err), 32'd0);
        step();

        // ---- m0 write 0x100 (cycle T) ----
        rst1 = 1'b0;
        rst3 = 1'b0;
        settle();
        chk("wr_gnt0", 32'(bus1.o_m0_gnt), 32'd1);
        chk("wr_gnt1", 32'(bus1.o_m1_gnt), 32'd0);
        chk("wr_we", 32'(bus1.o_mem_we), 32'd1);
        chk("wr_re", 32'(bus1.o_mem_re), 32'd0);
        chk("wr_addr", bus1.o_mem_addr, 32'h100);
        chk("wr_wdata", bus1.o_mem_wdata, 32'hDEADBEEF);
        step();

        // ---- m0 read 0x100 (T+1), data at T+2 ----
        bus1.i_m1_req = 1'b0;
        bus1.i_m0_ctrl = 2'b10;
        settle();
        chk("rd_gnt0", 32'(bus1.o_m0_gnt), 32'd1);
        chk("rd_re", 32'(bus1.o_mem_re), 32'd1);
        chk("rd_we", 32'(bus1.o_mem_we), 32'd0);
        chk("rd_addr", bus1.o_mem_addr, 32'h100);
        chk("rd_rvalid_early", 32'(bus1.o_m0_rvalid), 32'd0);
        step();
        bus1.i_m0_req = 1'b0;
        settle();
        chk("rd_rvalid0", 32'(bus1.o_m0_rvalid), 32'd1);
        chk("rd_rvalid1", 32'(bus1.o_m1_rvalid), 32'd0);
        chk("rd_rdata", bus1.o_m0_rdata, 32'hDEADBEEF);
        step();

        // ---- continuous reads from both ports: m0 x4 then m1 ----
        bus1.i_m0_req = 1'b1; bus1.i_m0_ctrl = 2'b10; bus1.i_m0_addr = 32'h100;
        bus1.i_m1_req = 1'b1; bus1.i_m1_ctrl = 2'b10; bus1.i_m1_addr = 32'h104;
        prev_m1 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            exp_m1 = ((i % 5) == 4);
            settle();
            chk($sformatf("str_gnt0_%0d", i), 32'(bus1.o_m0_gnt), 32'(!exp_m1));
            chk($sformatf("str_gnt1_%0d", i), 32'(bus1.o_m1_gnt), 32'(exp_m1));
            chk($sformatf("str_addr_%0d", i), bus1.o_mem_addr, exp_m1 ? 32'h104 : 32'h100);
            chk($sformatf("str_rv0_%0d", i), 32'(bus1.o_m0_rvalid), 32'((i > 0) && !prev_m1));
            chk($sformatf("str_rv1_%0d", i), 32'(bus1.o_m1_rvalid), 32'((i > 0) && prev_m1));
            if ((i > 0) && !prev_m1)
                chk($sformatf("str_rdata_%0d", i), bus1.o_m0_rdata, 32'hDEADBEEF);
            prev_m1 = exp_m1;
            step();
        end
        bus1.i_m0_req = 1'b0;
        bus1.i_m1_req = 1'b0;
        settle();
        chk("str_tail_rv1", 32'(bus1.o_m1_rvalid), 32'd1);
        chk("str_tail_rv0", 32'(bus1.o_m0_rvalid), 32'd0);
        step();

        // ---- m1 grant with ctrl 11 ----
        bus1.i_m1_req = 1'b1; bus1.i_m1_ctrl = 2'b11;
        bus1.i_m1_addr = 32'h108; bus1.i_m1_wdata = 32'h12345678;
        settle();
        chk("pe_gnt1", 32'(bus1.o_m1_gnt), 32'd1);
        chk("pe_we", 32'(bus1.o_mem_we), 32'd1);
        chk("pe_re", 32'(bus1.o_mem_re), 32'd0);
        chk("pe_addr", bus1.o_mem_addr, 32'h108);
        chk("pe_proto_same", 32'(bus1.o_proto_err), 32'd0);
        step();
        bus1.i_m1_req = 1'b0;
        settle();
        chk("pe_proto_next", 32'(bus1.o_proto_err), 32'd1);
        step();
        step();
        settle();
        chk("pe_proto_sticky", 32'(bus1.o_proto_err), 32'd1);
        rst1 = 1'b1;
        step();
        rst1 = 1'b0;
        settle();
        chk("pe_proto_clr", 32'(bus1.o_proto_err), 32'd0);
        step();

        // ---- RD_LATENCY=3: m1 read at T blocks m0 until T+3 ----
        bus3.i_m1_req = 1'b1; bus3.i_m1_ctrl = 2'b10; bus3.i_m1_addr = 32'h40;
        settle();
        chk("l3_gnt1", 32'(bus3.o_m1_gnt), 32'd1);
        chk("l3_re", 32'(bus3.o_mem_re), 32'd1);
        chk("l3_addr", bus3.o_mem_addr, 32'h40);
        step();
        bus3.i_m1_req = 1'b0;
        bus3.i_m0_req = 1'b1; bus3.i_m0_ctrl = 2'b10; bus3.i_m0_addr = 32'h80;
        settle();
        chk("l3_t1_gnt0", 32'(bus3.o_m0_gnt), 32'd0);
        chk("l3_t1_re", 32'(bus3.o_mem_re), 32'd0);
        chk("l3_t1_rv1", 32'(bus3.o_m1_rvalid), 32'd0);
        step();
        settle();
        chk("l3_t2_gnt0", 32'(bus3.o_m0_gnt), 32'd0);
        chk("l3_t2_rv1", 32'(bus3.o_m1_rvalid), 32'd0);
        step();
        settle();
        chk("l3_t3_rv1", 32'(bus3.o_m1_rvalid), 32'd1);
        chk("l3_t3_rdata1", bus3.o_m1_rdata, 32'hCAFE0003);
        chk("l3_t3_rv0", 32'(bus3.o_m0_rvalid), 32'd0);
        chk("l3_t3_gnt0", 32'(bus3.o_m0_gnt), 32'd1);
        chk("l3_t3_re", 32'(bus3.o_mem_re), 32'd1);
        chk("l3_t3_addr", bus3.o_mem_addr, 32'h80);
        step();
        bus3.i_m0_req = 1'b0;
        settle();
        chk("l3_t4_rv0", 32'(bus3.o_m0_rvalid), 32'd0);
        step();
        settle();
        chk("l3_t5_rv0", 32'(bus3.o_m0_rvalid), 32'd0);
        step();
        settle();
        chk("l3_t6_rv0", 32'(bus3.o_m0_rvalid), 32'd1);
        chk("l3_t6_rv1", 32'(bus3.o_m1_rvalid), 32'd0);
        step();

        // ---- RD_LATENCY=3: reset one cycle into a read drops it ----
        bus3.i_m0_req = 1'b1; bus3.i_m0_ctrl = 2'b10; bus3.i_m0_addr = 32'h84;
        settle();
        chk("rr_gnt0", 32'(bus3.o_m0_gnt), 32'd1);
        step();
        bus3.i_m0_req = 1'b0;
        rst3 = 1'b1;
        settle();
        chk("rr_rst_rv0", 32'(bus3.o_m0_rvalid), 32'd0);
        chk("rr_rst_re", 32'(bus3.o_mem_re), 32'd0);
        step();
        rst3 = 1'b0;
        settle();
        chk("rr_t2_rv0", 32'(bus3.o_m0_rvalid), 32'd0);
        step();
        bus3.i_m1_req = 1'b1; bus3.i_m1_ctrl = 2'b01;
        bus3.i_m1_addr = 32'h44; bus3.i_m1_wdata = 32'h55;
        settle();
        chk("rr_t3_rv0", 32'(bus3.o_m0_rvalid), 32'd0);
        chk("rr_fresh_gnt1", 32'(bus3.o_m1_gnt), 32'd1);
        chk("rr_fresh_we", 32'(bus3.o_mem_we), 32'd1);
        chk("rr_fresh_wdata", bus3.o_mem_wdata, 32'h55);
        step();
        bus3.i_m1_req = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arb.md
# mem_arb

Two-requester arbiter and sequencer for the single-port data memory behind the MEM stage. It multiplexes the pipeline MEM-stage port (m0) and a loader/debug port (m1) onto one memory port. It applies fixed priority to m0 with a bounded-starvation override for m1, and tracks each outstanding read until its data returns. It sits between the MEM stage and the data memory.

## Interface
Parameters:
- RD_LATENCY, 1: cycles from read strobe to valid `i_mem_rdata` (1..7).
- MAX_M0_STREAK, 4: consecutive contended m0 grants allowed before m1 is forced a grant (1..15).

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_m0_req  in  1  m0 request; held with addr/wdata/ctrl stable until granted
- i_m0_addr  in  32  m0 byte address
- i_m0_wdata  in  32  m0 store data
- i_m0_ctrl  in  mem_ctrl_t  m0 op: [1]=read, [0]=write
- o_m0_gnt  out  1  m0 request accepted this cycle
- o_m0_rvalid  out  1  m0 read data valid this cycle
- o_m0_rdata  out  32  m0 read data
- i_m1_req, i_m1_addr, i_m1_wdata, i_m1_ctrl, o_m1_gnt, o_m1_rvalid, o_m1_rdata: same as m0, for requester m1
- o_mem_addr  out  32  memory address
- o_mem_wdata  out  32  memory write data
- o_mem_we  out  1  memory write strobe
- o_mem_re  out  1  memory read strobe
- i_mem_rdata  in  32  memory read data
- o_proto_err  out  1  sticky: a granted request had ctrl == 2'b11

## Operation
- States:
  - IDLE: no read outstanding.
  - RD_WAIT: read outstanding. Holds a down-counter `rd_cnt` (3 bits) and the owner bit `rd_owner`.
- Arbitration-enabled cycle: state IDLE, or state RD_WAIT with `rd_cnt == 1` (the completion cycle).
- Grant rule in an enabled cycle:
  - Only one requester asserts req: grant it.
  - Both assert req: grant m0, unless `streak == MAX_M0_STREAK`, in which case grant m1.
- `streak` counter (4 bits):
  - +1 on each m0 grant while `i_m1_req` is high.
  - Cleared on an m1 grant, or in any cycle `i_m1_req` is low.
  - Saturates at MAX_M0_STREAK.
- Grant and memory drive are combinational in the grant cycle:
  - `o_mem_addr/wdata` come from the granted port.
  - `o_mem_we = ctrl[0]`, `o_mem_re = ctrl[1] & ~ctrl[0]`.
  - With no grant, `o_mem_addr/wdata` carry m0 values and both strobes are 0.
- Write grant, ctrl 01: completes in the grant cycle. No response cycle.
- Read grant, ctrl 10: next state RD_WAIT, `rd_cnt <= RD_LATENCY`, `rd_owner <=` granted port.
- ctrl 00 grant: no-op; granted, no strobes, no response.
- ctrl 11 grant: treated as a write. `o_proto_err` is set and stays set until reset.
- RD_WAIT:
  - `rd_cnt` decrements each cycle.
  - In the completion cycle, `o_mX_rvalid` for `rd_owner` = 1 and both `o_mX_rdata = i_mem_rdata`.
  - Next state: RD_WAIT if a new read is granted in that same cycle, else IDLE.
- Outside an enabled cycle, both `o_mX_gnt` = 0 and the strobes are 0.

## Timing
- Reset values, all registered state: state IDLE, `rd_cnt` 0, `rd_owner` 0, `streak` 0, `o_proto_err` 0.
- Outputs during the reset cycle: `o_mX_gnt`, `o_mX_rvalid`, `o_mem_we`, `o_mem_re` are 0. The gnt and strobe outputs are forced to 0 while `i_reset` = 1.
- Write latency: 0 cycles. Grant and `o_mem_we` occur in the same cycle as the request.
- Read latency: grant in cycle T, `o_rvalid` in cycle T+RD_LATENCY. No other rvalid pulses.
- Throughput:
  - RD_LATENCY=1: one read per cycle, since a new grant is allowed in the completion cycle.
  - RD_LATENCY=L: one read per L cycles.
  - Writes: one per enabled cycle.
- A request is not granted during non-completion RD_WAIT cycles. The requester holds req and its fields.
- `o_mX_gnt` is a one-cycle pulse per accepted request. Requester deasserts or changes req in the cycle after gnt.
- Reset mid-read: the outstanding read is dropped and no rvalid is produced. The read data is discarded.
- `o_mX_rdata` is `i_mem_rdata` in every cycle. It is meaningful only while rvalid is high.

## Test plan
- Reset: assert `i_reset` with both req high -> no gnt, strobes 0, `o_proto_err` 0. One cycle after release, m0 is granted.
- m0 write `addr=0x100, wdata=0xDEADBEEF`, then read `0x100` (RD_LATENCY=1) -> write gnt and `we` in cycle T. Read gnt in T+1, `o_m0_rvalid` in T+2 with rdata `0xDEADBEEF`.
- Continuous reads from both ports, MAX_M0_STREAK=4 -> grant sequence m0,m0,m0,m0,m1,m0,m0,m0,m0,m1,... `streak` never exceeds 4.
- RD_LATENCY=3, m1 read granted at T while m0 requests at T+1 -> m0 not granted at T+1 or T+2. m1 rvalid and m0 gnt both occur at T+3.
- Reset asserted at T+1 of a RD_LATENCY=3 read -> no rvalid at T+3, state IDLE, a fresh request is granted after release.
- m1 granted with ctrl=2'b11 -> `o_mem_we`=1, `o_mem_re`=0, `o_proto_err` goes high the next cycle and stays high until reset.
